cbus_mem_responder: RTL and testbench

- Synthesizable CBus slave: the responder end of the cached-bus interface that the arbiter and address-translation path drive as `oreq`/`oresp`.
- Holds a word-addressed memory array and services single-beat and INCR bursts, reads and byte-strobed writes.
- Optional programmable first-beat latency and pseudo-random beat stalls, so the core/arbiter path can be exercised standalone in simulation and on FPGA without the external memory model.

---
 rtl/cbus_mem_responder.sv | 145 ++++++++++++++
 tb/tb_cbus_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_mem_responder.sv
// CBus memory responder: word-addressed array serving
// single-beat and INCR bursts with optional latency/stalls.
package cbus_pkg;
   typedef enum logic [3:0] {
      MLEN1, MLEN2, MLEN3, MLEN4,
      MLEN5, MLEN6, MLEN7, MLEN8,
      MLEN9, MLEN10, MLEN11, MLEN12,
      MLEN13, MLEN14, MLEN15, MLEN16
   } cbus_len_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_mem_responder
   import cbus_pkg::*;
#(
   parameter int          MEM_WORDS     = 65536,
   parameter int          FIRST_LATENCY = 2,
   parameter bit          STALL_EN      = 1'b0,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  creq,
   output cbus_resp_t cresp
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [3:0] LAT_LAST =
      4'(FIRST_LATENCY == 0 ? 0 : FIRST_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE, WAIT, BEAT
   } state_t;

   state_t         state_q;
   logic [3:0]     cnt_q;
   logic [3:0]     lat_q;
   logic [3:0]     len_q;
   logic           wr_q;
   logic [AW-1:0]  idx_q;
   logic [15:0]    lfsr_q;
   logic [15:0]    lfsr_d;
   logic [31:0]    mem_q [MEM_WORDS];

   logic [AW-1:0]  ptr;
   logic           stall;
   logic           rdy;
   logic           lst;
   logic           we;

   // Galois step, taps 16,14,13,11
   assign lfsr_d = {1'b0, lfsr_q[15:1]}
                 ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   assign ptr   = idx_q + AW'(cnt_q);
   assign stall = STALL_EN && (lfsr_q[1:0] == 2'b00);
   assign rdy   = (state_q == BEAT) && !stall;
   assign lst   = rdy && (cnt_q == len_q);
   assign we    = rdy && creq.valid && wr_q;

   // Response is a pure function of registered state
   always_comb begin
      cresp       = '0;
      cresp.ready = rdy;
      cresp.last  = lst;
      if (state_q == BEAT)
         cresp.data = mem_q[ptr];
   end

   // Request sequencing: accept, wait latency, stream beats
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lat_q   <= '0;
         len_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         lfsr_q  <= LFSR_SEED;
      end else begin
         if (state_q == BEAT)
            lfsr_q <= lfsr_d;
         unique case (state_q)
            IDLE: begin
               if (creq.valid) begin
                  idx_q   <= creq.addr[AW+1:2];
                  len_q   <= creq.len;
                  wr_q    <= creq.is_write;
                  cnt_q   <= '0;
                  lat_q   <= '0;
                  state_q <= (FIRST_LATENCY > 0)
                           ? WAIT : BEAT;
               end
            end
            WAIT: begin
               if (!creq.valid)
                  state_q <= IDLE;
               else if (lat_q == LAT_LAST)
                  state_q <= BEAT;
               else
                  lat_q <= lat_q + 4'd1;
            end
            BEAT: begin
               if (!creq.valid)
                  state_q <= IDLE;
               else if (rdy) begin
                  if (lst)
                     state_q <= IDLE;
                  else
                     cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Byte-strobed array write; a beat colliding with reset is dropped
   always_ff @(posedge clk) begin
      if (!reset && we) begin
         for (int i = 0; i < 4; i++) begin
            if (creq.strobe[i])
               mem_q[ptr][8*i +: 8] <= creq.data[8*i +: 8];
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{creq.size, creq.addr[1:0],
                        creq.addr[31:AW+2]};
endmodule

// File: tb/tb_cbus_mem_responder.sv
// Directed scoreboard bench for cbus_mem_responder.
// Drives one request bus, steered to a plain or stalling instance.
module tb_cbus_mem_responder;
   import cbus_pkg::*;

   localparam int LAT = 2;
   localparam int W0  = 65536;
   localparam int W1  = 1024;
   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk;
   logic       reset;
   logic       sel;
   cbus_req_t  req;
   cbus_req_t  q0;
   cbus_req_t  q1;
   cbus_resp_t r0;
   cbus_resp_t r1;
   cbus_resp_t rs;

   int total;
   int bad;

   logic [31:0] wd [16];
   logic [31:0] mdl0 [int];
   logic [31:0] mdl1 [int];
   logic [31:0] sbq [$];
   logic [15:0] lfsr_m;

   cbus_mem_responder #(
      .MEM_WORDS(W0), .FIRST_LATENCY(LAT),
      .STALL_EN(1'b0), .LFSR_SEED(SEED)
   ) dut0 (
      .clk(clk), .reset(reset),
      .creq(q0), .cresp(r0)
   );

   cbus_mem_responder #(
      .MEM_WORDS(W1), .FIRST_LATENCY(LAT),
      .STALL_EN(1'b1), .LFSR_SEED(SEED)
   ) dut1 (
      .clk(clk), .reset(reset),
      .creq(q1), .cresp(r1)
   );

   always_comb begin
      q0 = req;
      q1 = req;
      q0.valid = req.valid && !sel;
      q1.valid = req.valid && sel;
      rs = sel ? r1 : r0;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lstep(
      input logic [15:0] v);
      logic [15:0] n;
      n = v >> 1;
      if (v[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [31:0] rd_mdl(input bit s,
                                          input int i);
      if (s) return mdl1.exists(i) ? mdl1[i] : 32'h0;
      return mdl0.exists(i) ? mdl0[i] : 32'h0;
   endfunction

   task automatic wr_mdl(input bit s, input int i,
                         input logic [3:0] st,
                         input logic [31:0] d);
      logic [31:0] w;
      w = rd_mdl(s, i);
      for (int b = 0; b < 4; b++)
         if (st[b]) w[8*b +: 8] = d[8*b +: 8];
      if (s) mdl1[i] = w;
      else mdl0[i] = w;
   endtask

   // Entered just after a posedge; leaves just after a posedge.
   task automatic xact(input bit s, input bit wr,
                       input logic [31:0] addr,
                       input int nb,
                       input logic [3:0] st,
                       input bit keep,
                       input int rst_at);
      int words;
      int base;
      int beat;
      int cyc;
      bit er;
      bit in_rst;
      words = s ? W1 : W0;
      base  = int'(addr >> 2) & (words - 1);
      sel   = s;
      req.is_write = wr;
      req.addr     = addr;
      req.size     = 2'd2;
      req.len      = cbus_len_t'(4'(nb - 1));
      req.strobe   = st;
      req.data     = wd[0];
      req.valid    = 1'b1;
      if (!wr)
         for (int b = 0; b < nb; b++)
            sbq.push_back(
               rd_mdl(s, (base + b) & (words - 1)));
      beat   = 0;
      cyc    = 0;
      in_rst = 1'b0;
      while (1) begin
         @(negedge clk);
         if (cyc <= LAT) er = 1'b0;
         else if (s) er = (lfsr_m[1:0] != 2'b00);
         else er = 1'b1;
         if (cyc > LAT && s) lfsr_m = lstep(lfsr_m);
         chk("ready", 32'(rs.ready), 32'(er));
         if (er) begin
            chk("last", 32'(rs.last),
                32'(beat == nb - 1));
            if (!wr) begin
               if (sbq.size() == 0)
                  chk("sb_empty", 32'd1, 32'd0);
               else
                  chk("rdata", rs.data, sbq.pop_front());
            end else if (!in_rst) begin
               wr_mdl(s, (base + beat) & (words - 1),
                      st, wd[beat]);
            end
            beat++;
         end else begin
            chk("last_idle", 32'(rs.last), 32'd0);
         end
         @(posedge clk);
         #1;
         cyc++;
         if (in_rst) begin
            reset     = 1'b0;
            req.valid = 1'b0;
            lfsr_m    = SEED;
            break;
         end
         if (beat == nb) begin
            if (!keep) req.valid = 1'b0;
            break;
         end
         if (cyc > 200) begin
            chk("timeout", 32'(cyc), 32'd0);
            req.valid = 1'b0;
            break;
         end
         if (er) req.data = wd[beat];
         if (er && beat == rst_at) begin
            reset  = 1'b1;
            in_rst = 1'b1;
         end
      end
   endtask

   task automatic idle_chk(input string tag);
      @(negedge clk);
      chk(tag, 32'(rs.ready), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      sel    = 1'b0;
      req    = '0;
      reset  = 1'b1;
      lfsr_m = SEED;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready0", 32'(r0.ready), 32'd0);
      chk("rst_last0", 32'(r0.last), 32'd0);
      chk("rst_data0", r0.data, 32'd0);
      chk("rst_ready1", 32'(r1.ready), 32'd0);
      @(posedge clk);
      #1;

      // single read with 3-cycle first-beat latency
      wd[0] = 32'hDEADBEEF;
      xact(0, 1, 32'h100, 1, 4'hF, 0, -1);
      xact(0, 0, 32'h100, 1, 4'hF, 0, -1);
      idle_chk("after_last");
      chk("deadbeef", rd_mdl(0, 32'h40), 32'hDEADBEEF);
      xact(0, 0, 32'h103, 1, 4'hF, 0, -1);

      // strobed write merges bytes 0 and 2
      wd[0] = 32'h11223344;
      xact(0, 1, 32'h40, 1, 4'hF, 0, -1);
      wd[0] = 32'hAABBCCDD;
      xact(0, 1, 32'h40, 1, 4'b0101, 0, -1);
      sbq.push_back(32'h11BB33DD);
      xact(0, 0, 32'h40, 1, 4'hF, 0, -1);
      sbq.delete();

      // 16-beat burst wrapping past the top word
      for (int k = 0; k < 16; k++)
         wd[k] = 32'hC0DE0000 | 32'(k * 3 + 1);
      xact(0, 1, 32'h3FFC8, 16, 4'hF, 0, -1);
      xact(0, 0, 32'h3FFC8, 16, 4'hF, 0, -1);
      chk("wrap_lo", rd_mdl(0, 0), 32'hC0DE0000 | 32'd43);

      // stalling instance, 8-beat write and read-back
      for (int k = 0; k < 8; k++)
         wd[k] = 32'(k) * 32'h01010101;
      xact(1, 1, 32'h200, 8, 4'hF, 0, -1);
      xact(1, 0, 32'h200, 8, 4'hF, 0, -1);
      chk("stall_w7", rd_mdl(1, 32'h87), 32'h07070707);

      // back-to-back reads with valid held through last
      for (int k = 0; k < 4; k++)
         wd[k] = 32'h5A000000 + 32'(k);
      xact(0, 1, 32'h800, 4, 4'hF, 0, -1);
      xact(0, 0, 32'h800, 4, 4'hF, 1, -1);
      xact(0, 0, 32'h100, 1, 4'hF, 0, -1);

      // reset landing on beat 3 of an 8-beat write
      for (int k = 0; k < 8; k++)
         wd[k] = 32'hA0A0A000 + 32'(k);
      xact(0, 1, 32'h1000, 8, 4'hF, 0, -1);
      for (int k = 0; k < 8; k++)
         wd[k] = 32'hB0B0B000 + 32'(k);
      xact(0, 1, 32'h1000, 8, 4'hF, 0, 3);
      idle_chk("post_reset");
      chk("rst_b2", rd_mdl(0, 32'h402), 32'hB0B0B002);
      chk("rst_b3", rd_mdl(0, 32'h403), 32'hA0A0A003);
      xact(0, 0, 32'h1000, 8, 4'hF, 0, -1);
      xact(1, 0, 32'h200, 8, 4'hF, 0, -1);

      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
